ram_port_arbiter: RTL



---
 rtl/ram_port_arbiter_pkg.sv | 22 ++
 rtl/ram_port_arbiter_if.sv | 63 ++++++
 rtl/ram_port_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared owner encoding and sizing helpers
// for the IF/MEM single-port RAM arbiter.
package ram_port_arbiter_pkg;

  localparam int ARB_OWNER_BUS = 2;

  typedef enum logic [ARB_OWNER_BUS-1:0] {
    OWNER_NONE = 2'b00,
    OWNER_INST = 2'b01,
    OWNER_DATA = 2'b10
  } owner_e;

  function automatic int streak_w(
    input int max_streak
  );
    if (max_streak < 1) begin
      return 1;
    end
    return $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Fetch, data and RAM command bundle
// shared by the arbiter and its neighbours.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) ();

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_valid;

  logic              data_req;
  logic [SEL_W-1:0]  data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_valid;

  logic              ram_en;
  logic [SEL_W-1:0]  ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_rdata,
    input  inst_valid,
    output data_req,
    output data_we,
    output data_addr,
    output data_wdata,
    input  data_rdata,
    input  data_valid,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_rdata,
    output inst_valid,
    input  data_req,
    input  data_we,
    input  data_addr,
    input  data_wdata,
    output data_rdata,
    output data_valid,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Arbitrates one sync-read RAM between fetch and
// MEM; data wins ties until the streak limit.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int SEL_W           = 4,
  parameter int MAX_DATA_STREAK = 4
) (
  input logic                clk,
  input logic                rst,
  ram_port_arbiter_if.slave  bus
);

  localparam int SW = streak_w(MAX_DATA_STREAK);
  localparam logic [SW-1:0] STREAK_MAX =
    SW'(MAX_DATA_STREAK);

  owner_e          owner_q;
  owner_e          owner_d;
  owner_e          grant;
  logic            wr_q;
  logic            wr_d;
  logic [SW-1:0]   streak_q;
  logic [SW-1:0]   streak_d;

  logic            inst_elig;
  logic            data_elig;

  logic              en_c;
  logic [SEL_W-1:0]  we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  // Pick the winner; a requester awaiting its
  // response is ignored in that cycle.
  always_comb begin
    inst_elig = bus.inst_req &&
                (owner_q != OWNER_INST);
    data_elig = bus.data_req &&
                (owner_q != OWNER_DATA);
    grant = OWNER_NONE;
    if (inst_elig && data_elig) begin
      if (streak_q == STREAK_MAX) begin
        grant = OWNER_INST;
      end else begin
        grant = OWNER_DATA;
      end
    end else if (data_elig) begin
      grant = OWNER_DATA;
    end else if (inst_elig) begin
      grant = OWNER_INST;
    end
  end

  // Steer the winner onto the RAM command;
  // fetch never writes, reset silences the RAM.
  always_comb begin
    en_c    = 1'b0;
    we_c    = '0;
    addr_c  = '0;
    wdata_c = '0;
    if (!rst) begin
      unique case (grant)
        OWNER_INST: begin
          en_c   = 1'b1;
          addr_c = bus.inst_addr;
        end
        OWNER_DATA: begin
          en_c    = 1'b1;
          we_c    = bus.data_we;
          addr_c  = bus.data_addr;
          wdata_c = bus.data_wdata;
        end
        default: begin
          en_c = 1'b0;
        end
      endcase
    end
  end

  assign bus.ram_en    = en_c;
  assign bus.ram_we    = we_c;
  assign bus.ram_addr  = addr_c;
  assign bus.ram_wdata = wdata_c;

  // Next owner, write flag and fetch-starvation
  // streak.
  always_comb begin
    owner_d  = grant;
    wr_d     = (grant == OWNER_DATA) &&
               (|bus.data_we);
    streak_d = streak_q;
    if (!bus.inst_req ||
        (grant == OWNER_INST)) begin
      streak_d = '0;
    end else if ((grant == OWNER_DATA) &&
                 (owner_q != OWNER_INST) &&
                 (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  // Owner FSM and streak state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWNER_NONE;
      wr_q     <= 1'b0;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      streak_q <= streak_d;
    end
  end

  // Response decode straight from the owner
  // register; write acks carry no data.
  always_comb begin
    bus.inst_valid = (owner_q == OWNER_INST);
    bus.data_valid = (owner_q == OWNER_DATA);
    bus.inst_rdata = '0;
    bus.data_rdata = '0;
    if (owner_q == OWNER_INST) begin
      bus.inst_rdata = bus.ram_rdata;
    end
    if ((owner_q == OWNER_DATA) && !wr_q) begin
      bus.data_rdata = bus.ram_rdata;
    end
  end

  a_one_valid: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.inst_valid && bus.data_valid)
  );

  a_owner_legal: assert property (
    @(posedge clk) disable iff (rst)
    owner_q != owner_e'(2'b11)
  );

  a_streak_sat: assert property (
    @(posedge clk) disable iff (rst)
    streak_q <= STREAK_MAX
  );

  a_inst_no_write: assert property (
    @(posedge clk) disable iff (rst)
    (grant == OWNER_INST) |-> (bus.ram_we == '0)
  );

endmodule
